exe_branch_unit: RTL and testbench
==================================

Name: exe_branch_unit

Overview:
- Parametrised, registered branch/jump execution unit between the branch reservation station and the common data bus (CDB).
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, checks the front-end prediction, and broadcasts the link value on the CDB under a grant handshake.
- Raises a one-cycle redirect on a mispredict.
- Holds one result in an output register and stalls issue while the CDB grant is withheld.

Parameters:
- XLEN, 32, operand/address width.
- TAG_W, 6, reservation/ROB tag width; tag 0 means "no destination".

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; kills the held and incoming entry
- in_valid  in  1  issue request from the RS
- in_ready  out  1  unit can accept this cycle
- in_op  in  10  [9:3] class: 1000000 JALR, 0100000 JAL, 0000000 branch; [2:0] funct3
- in_tag  in  TAG_W  destination tag
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended offset
- in_opr1  in  XLEN  rs1 value
- in_opr2  in  XLEN  rs2 value
- in_pred_taken  in  1  front-end predicted direction
- in_pred_target  in  XLEN  front-end predicted target
- cdb_req  out  1  CDB broadcast request
- cdb_grant  in  1  CDB arbiter grant
- cdb_tag  out  TAG_W  broadcast tag
- cdb_value  out  XLEN  broadcast value (link = pc+4)
- redir_valid  out  1  mispredict redirect pulse
- redir_tag  out  TAG_W  tag of the mispredicted instruction
- redir_pc  out  XLEN  correct next PC

Behaviour:
- Reset (async): cdb_req=0, redir_valid=0, cdb_tag=0, cdb_value=0, redir_tag=0, redir_pc=0, internal hold_valid=0. in_ready=1 after reset.
- Accept: in_valid && in_ready && !flush at a rising edge.
- in_ready = !hold_valid || (cdb_req && cdb_grant). This gives full throughput under continuous grant.
- Compute, combinational on the issue inputs, registered at accept:
  - link = pc+4.
  - JAL target = pc+imm.
  - JALR target = (opr1+imm) & ~1.
  - Branch target = pc+imm.
  - All additions are modulo 2^XLEN; wrap-around is permitted and not flagged.
- Direction:
  - funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - funct3 010/011 resolve as not-taken.
  - JAL/JALR are always taken.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
- next_pc = taken ? target : link.
- Latency 1: on the cycle after accept, redir_valid=1 for exactly one cycle if mispredict, with redir_tag=in_tag and redir_pc=next_pc. The pulse is independent of cdb_grant.
- CDB:
  - Jumps with tag!=0 set hold_valid and drive cdb_req=1, cdb_tag and cdb_value=link, held stable until cdb_grant.
  - Release happens on the edge where cdb_req && cdb_grant.
  - Branches, jumps with tag 0, and unknown classes do not occupy the hold register and never raise cdb_req.
- Unknown class: accepted and dropped; no CDB, no redirect.
- Flush (synchronous, highest priority):
  - Clears hold_valid and cdb_req next edge.
  - Suppresses any redirect for an entry accepted in the flush cycle.
  - A redir_valid already asserted in the flush cycle still completes its single cycle.
- Simultaneous grant and new accept: the old entry retires and the new one loads in the same edge; there is no bubble.
- cdb_grant while cdb_req=0 is ignored.
- Reset mid-operation: all state is cleared immediately; a pending broadcast is lost.

Optional Feature:
- BRU_PERF_CNT_EN defined adds three outputs:
  - perf_branches (32-bit): count of accepted branch/jump entries.
  - perf_mispred (32-bit): count of redir_valid pulses.
  - perf_stall (32-bit): cycles with cdb_req && !cdb_grant.
  - All counters wrap, are cleared by rst, and ignore flush.
- Undefined: the counter logic and ports are absent; all other behaviour is identical.

Test Plan:
- BEQ opr1=5, opr2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle redir_valid=1, redir_pc=0x120; cdb_req stays 0.
- BLT opr1=0xFFFFFFFF, opr2=1, pred_taken=1, pred_target=pc+imm -> taken (signed), no redirect. Same operands as BLTU -> not taken, redir_pc=pc+4.
- JALR opr1=0x1003, imm=0, tag=7, pred_target=0x1002, cdb_grant held 0 for 3 cycles:
  - No redirect.
  - cdb_req=1 with tag=7, value=pc+4, stable.
  - in_ready=0 until grant.
  - Release on the grant edge.
- Back-to-back JALs with cdb_grant=1 every cycle -> one CDB broadcast per cycle, in_ready constantly 1.
- JAL accepted with mispredict in the same cycle as flush=1 -> no redir_valid, no cdb_req. A held, ungranted jump is cleared by flush.
- rst asserted while cdb_req=1 -> all outputs 0 asynchronously. With BRU_PERF_CNT_EN defined, the counters also read 0.

Source files
------------

// File: rtl/exe_branch_unit.sv
// exe_branch_unit: registered branch/jump execution unit.
// Resolves conditional branches and JAL/JALR, checks the front-end prediction,
// pulses a one-cycle redirect on mispredict and broadcasts the link value of
// jumps with a destination tag on the CDB, holding it until granted.
// Optional build macro BRU_PERF_CNT_EN adds perf_branches/perf_mispred/perf_stall.
module exe_branch_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_opr1,
   input  logic [XLEN-1:0]  in_opr2,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [XLEN-1:0]  cdb_value,
   output logic             redir_valid,
   output logic [TAG_W-1:0] redir_tag,
   output logic [XLEN-1:0]  redir_pc
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]      perf_branches,
   output logic [31:0]      perf_mispred,
   output logic [31:0]      perf_stall
`endif
);

   localparam logic [6:0] CLS_JALR = 7'b1000000;
   localparam logic [6:0] CLS_JAL  = 7'b0100000;
   localparam logic [6:0] CLS_BR   = 7'b0000000;

   localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'd4};
   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   logic             hold_valid_q, hold_valid_d;
   logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
   logic             redir_valid_q, redir_valid_d;
   logic [TAG_W-1:0] redir_tag_q, redir_tag_d;
   logic [XLEN-1:0]  redir_pc_q, redir_pc_d;

   logic             is_jal, is_jalr, is_br, is_jump, is_known;
   logic             br_taken, taken, mispred;
   logic [XLEN-1:0]  link, target, next_pc;
   logic             accept, release_hold;

   // Accept/ready handshake; a granted entry frees the slot in the same cycle
   assign release_hold = hold_valid_q && cdb_grant;
   assign in_ready     = !hold_valid_q || release_hold;
   assign accept       = in_valid && in_ready && !flush;

   // Resolve direction, target and prediction check from the issue inputs
   always_comb begin
      is_jalr  = (in_op[9:3] == CLS_JALR);
      is_jal   = (in_op[9:3] == CLS_JAL);
      is_br    = (in_op[9:3] == CLS_BR);
      is_jump  = is_jal || is_jalr;
      is_known = is_jump || is_br;
      link     = in_pc + FOUR;
      target   = is_jalr ? ((in_opr1 + in_imm) & JALR_MASK) : (in_pc + in_imm);
      br_taken = 1'b0;
      case (in_op[2:0])
         3'b000:  br_taken = (in_opr1 == in_opr2);
         3'b001:  br_taken = (in_opr1 != in_opr2);
         3'b100:  br_taken = ($signed(in_opr1) <  $signed(in_opr2));
         3'b101:  br_taken = ($signed(in_opr1) >= $signed(in_opr2));
         3'b110:  br_taken = (in_opr1 <  in_opr2);
         3'b111:  br_taken = (in_opr1 >= in_opr2);
         default: br_taken = 1'b0;
      endcase
      taken   = is_jump || (is_br && br_taken);
      mispred = (taken != in_pred_taken) || (taken && (target != in_pred_target));
      next_pc = taken ? target : link;
   end

   // Next-state for the CDB hold register and the redirect pulse
   always_comb begin
      hold_valid_d  = hold_valid_q;
      cdb_tag_d     = cdb_tag_q;
      cdb_value_d   = cdb_value_q;
      redir_valid_d = 1'b0;
      redir_tag_d   = redir_tag_q;
      redir_pc_d    = redir_pc_q;
      if (release_hold)
         hold_valid_d = 1'b0;
      if (accept && is_jump && (in_tag != '0)) begin
         hold_valid_d = 1'b1;
         cdb_tag_d    = in_tag;
         cdb_value_d  = link;
      end
      if (accept && is_known && mispred) begin
         redir_valid_d = 1'b1;
         redir_tag_d   = in_tag;
         redir_pc_d    = next_pc;
      end
      // Flush wins over everything; accept is already blocked by it
      if (flush)
         hold_valid_d = 1'b0;
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_q  <= 1'b0;
         cdb_tag_q     <= '0;
         cdb_value_q   <= '0;
         redir_valid_q <= 1'b0;
         redir_tag_q   <= '0;
         redir_pc_q    <= '0;
      end else begin
         hold_valid_q  <= hold_valid_d;
         cdb_tag_q     <= cdb_tag_d;
         cdb_value_q   <= cdb_value_d;
         redir_valid_q <= redir_valid_d;
         redir_tag_q   <= redir_tag_d;
         redir_pc_q    <= redir_pc_d;
      end
   end

   assign cdb_req     = hold_valid_q;
   assign cdb_tag     = cdb_tag_q;
   assign cdb_value   = cdb_value_q;
   assign redir_valid = redir_valid_q;
   assign redir_tag   = redir_tag_q;
   assign redir_pc    = redir_pc_q;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_mispred_q, perf_mispred_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Free-running wrap-around event counters; flush does not affect them
   always_comb begin
      perf_branches_d = perf_branches_q + {31'd0, (accept && is_known)};
      perf_mispred_d  = perf_mispred_q + {31'd0, redir_valid_q};
      perf_stall_d    = perf_stall_q + {31'd0, (hold_valid_q && !cdb_grant)};
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branches_q <= '0;
         perf_mispred_q  <= '0;
         perf_stall_q    <= '0;
      end else begin
         perf_branches_q <= perf_branches_d;
         perf_mispred_q  <= perf_mispred_d;
         perf_stall_q    <= perf_stall_d;
      end
   end

   assign perf_branches = perf_branches_q;
   assign perf_mispred  = perf_mispred_q;
   assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_exe_branch_unit.sv
// Scoreboard bench for exe_branch_unit: directed issues push expected
// redirects / CDB broadcasts into queues; a negedge monitor pops and compares.
module tb_exe_branch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  in_op = '0;
   logic [5:0]  in_tag = '0;
   logic [31:0] in_pc = '0, in_imm = '0, in_opr1 = '0, in_opr2 = '0;
   logic        in_pred_taken = 1'b0;
   logic [31:0] in_pred_target = '0;
   logic        cdb_req;
   logic        cdb_grant = 1'b0;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        redir_valid;
   logic [5:0]  redir_tag;
   logic [31:0] redir_pc;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct { logic [5:0] tag; logic [31:0] val; } exp_t;
   exp_t rq[$];
   exp_t cq[$];

   localparam logic [9:0] OP_BEQ  = {7'b0000000, 3'b000};
   localparam logic [9:0] OP_BNE  = {7'b0000000, 3'b001};
   localparam logic [9:0] OP_B010 = {7'b0000000, 3'b010};
   localparam logic [9:0] OP_BLT  = {7'b0000000, 3'b100};
   localparam logic [9:0] OP_BGE  = {7'b0000000, 3'b101};
   localparam logic [9:0] OP_BLTU = {7'b0000000, 3'b110};
   localparam logic [9:0] OP_BGEU = {7'b0000000, 3'b111};
   localparam logic [9:0] OP_JAL  = {7'b0100000, 3'b000};
   localparam logic [9:0] OP_JALR = {7'b1000000, 3'b000};
   localparam logic [9:0] OP_UNK  = {7'b0010000, 3'b000};

   exe_branch_unit #(.XLEN(32), .TAG_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
      .in_pc(in_pc), .in_imm(in_imm), .in_opr1(in_opr1), .in_opr2(in_opr2),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .redir_valid(redir_valid), .redir_tag(redir_tag), .redir_pc(redir_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_redir(input logic [5:0] t, input logic [31:0] v);
      exp_t e; e.tag = t; e.val = v; rq.push_back(e);
   endtask

   task automatic exp_cdb(input logic [5:0] t, input logic [31:0] v);
      exp_t e; e.tag = t; e.val = v; cq.push_back(e);
   endtask

   // Drive one request (called at posedge+1) and hold it until accepted
   task automatic issue(input logic [9:0] op, input logic [5:0] tag, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] o1, input logic [31:0] o2,
                        input logic pt, input logic [31:0] ptgt);
      int w;
      in_valid = 1'b1; in_op = op; in_tag = tag; in_pc = pc; in_imm = imm;
      in_opr1 = o1; in_opr2 = o2; in_pred_taken = pt; in_pred_target = ptgt;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         w++;
         @(negedge clk);
      end
      if (w >= 20) chk("issue_timeout", 64'(w), 64'(0));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Monitor: every redirect pulse and every granted broadcast must be expected
   always @(negedge clk) begin
      if (!rst) begin
         if (redir_valid) begin
            if (rq.size() == 0) chk("redir_unexpected", {58'd0, redir_tag}, 64'hdead);
            else begin
               exp_t e;
               e = rq.pop_front();
               chk("redir_tag", {58'd0, redir_tag}, {58'd0, e.tag});
               chk("redir_pc", {32'd0, redir_pc}, {32'd0, e.val});
            end
         end
         if (cdb_req && cdb_grant) begin
            if (cq.size() == 0) chk("cdb_unexpected", {58'd0, cdb_tag}, 64'hdead);
            else begin
               exp_t e;
               e = cq.pop_front();
               chk("cdb_tag", {58'd0, cdb_tag}, {58'd0, e.tag});
               chk("cdb_value", {32'd0, cdb_value}, {32'd0, e.val});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_cdb_req", {63'd0, cdb_req}, 64'd0);
      chk("rst_redir_valid", {63'd0, redir_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_cdb_value", {32'd0, cdb_value}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // BEQ taken, predicted not-taken -> redirect to pc+imm
      exp_redir(6'd3, 32'h120);
      issue(OP_BEQ, 6'd3, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0);
      @(negedge clk); chk("beq_no_cdb", {63'd0, cdb_req}, 64'd0);
      @(posedge clk); #1;
      // BLT signed: -1 < 1 taken, correctly predicted
      issue(OP_BLT, 6'd4, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h240);
      // BLTU same operands: not taken -> redirect to pc+4
      exp_redir(6'd4, 32'h204);
      issue(OP_BLTU, 6'd4, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h240);
      // BNE taken with negative offset, correct
      issue(OP_BNE, 6'd2, 32'h300, 32'hFFFFFFF8, 32'd1, 32'd2, 1'b1, 32'h2F8);
      // BGE signed: min_int >= 0 false, correct not-taken
      issue(OP_BGE, 6'd5, 32'h400, 32'h10, 32'h80000000, 32'd0, 1'b0, 32'h0);
      // BGEU same operands: taken -> redirect pc+imm
      exp_redir(6'd5, 32'h410);
      issue(OP_BGEU, 6'd5, 32'h400, 32'h10, 32'h80000000, 32'd0, 1'b0, 32'h0);
      // funct3 010 resolves not-taken; predicted taken -> redirect pc+4
      exp_redir(6'd6, 32'h504);
      issue(OP_B010, 6'd6, 32'h500, 32'h40, 32'd1, 32'd1, 1'b1, 32'h540);
      // Right direction, wrong target
      exp_redir(6'd8, 32'h608);
      issue(OP_BEQ, 6'd8, 32'h600, 32'h8, 32'd9, 32'd9, 1'b1, 32'h999);
      // JAL tag 0 with address wrap, correct prediction: nothing visible
      issue(OP_JAL, 6'd0, 32'hFFFFFFFC, 32'h8, 32'd0, 32'd0, 1'b1, 32'h4);
      @(negedge clk); chk("jal_tag0_no_cdb", {63'd0, cdb_req}, 64'd0);
      @(posedge clk); #1;
      // Unknown class dropped even with a wrong prediction
      issue(OP_UNK, 6'd9, 32'h680, 32'h8, 32'd1, 32'd1, 1'b1, 32'h0);
      @(negedge clk); chk("unk_no_cdb", {63'd0, cdb_req}, 64'd0);
      @(posedge clk); #1;
      // JAL mispredicted direction, tag 0 -> redirect only
      exp_redir(6'd0, 32'h940);
      issue(OP_JAL, 6'd0, 32'h900, 32'h40, 32'd0, 32'd0, 1'b0, 32'h0);

      // JALR stall: target (0x1003+0)&~1 = 0x1002 predicted correctly
      exp_cdb(6'd7, 32'h704);
      issue(OP_JALR, 6'd7, 32'h700, 32'h0, 32'h1003, 32'd0, 1'b1, 32'h1002);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("jalr_req", {63'd0, cdb_req}, 64'd1);
         chk("jalr_tag", {58'd0, cdb_tag}, 64'd7);
         chk("jalr_val", {32'd0, cdb_value}, 64'h704);
         chk("jalr_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1 cdb_grant = 1'b1;
      @(negedge clk); chk("grant_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk); chk("jalr_released", {63'd0, cdb_req}, 64'd0);

      // Back-to-back JALs under continuous grant
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_op = OP_JAL; in_tag = 6'(10 + i);
         in_pc = 32'h800 + 32'(4 * i); in_imm = 32'h100;
         in_pred_taken = 1'b1; in_pred_target = 32'h900 + 32'(4 * i);
         exp_cdb(6'(10 + i), 32'h804 + 32'(4 * i));
         @(negedge clk); chk("b2b_ready", {63'd0, in_ready}, 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1 cdb_grant = 1'b0;
      @(negedge clk); chk("b2b_drained", {63'd0, cdb_req}, 64'd0);

      // Mispredicted JAL accepted together with flush: fully suppressed
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = OP_JAL; in_tag = 6'd14; in_pc = 32'hA00; in_imm = 32'h10;
      in_pred_taken = 1'b0; flush = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_no_redir", {63'd0, redir_valid}, 64'd0);
      chk("flush_no_req", {63'd0, cdb_req}, 64'd0);
      // Held, ungranted jump cleared by flush
      @(posedge clk); #1;
      issue(OP_JAL, 6'd15, 32'hB00, 32'h20, 32'd0, 32'd0, 1'b1, 32'hB20);
      @(negedge clk); chk("held_req", {63'd0, cdb_req}, 64'd1);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_clears_req", {63'd0, cdb_req}, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);

      // Asynchronous reset with a pending broadcast
      @(posedge clk); #1;
      issue(OP_JAL, 6'd16, 32'hC00, 32'h4, 32'd0, 32'd0, 1'b1, 32'hC04);
      @(negedge clk); chk("pre_rst_req", {63'd0, cdb_req}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_req", {63'd0, cdb_req}, 64'd0);
      chk("arst_tag", {58'd0, cdb_tag}, 64'd0);
      chk("arst_val", {32'd0, cdb_value}, 64'd0);
      chk("arst_redir_tag", {58'd0, redir_tag}, 64'd0);
      chk("arst_redir_pc", {32'd0, redir_pc}, 64'd0);
      chk("arst_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      chk("redir_queue_empty", 64'(rq.size()), 64'd0);
      chk("cdb_queue_empty", 64'(cq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
